// File: rtl/mips_reg_pkg.sv
// Shared MIPS register-file definitions: register indices, reserved-index mask,
// access-owner and lock-state encodings used by the register-file arbiter.
package mips_reg_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0,  REG_AT = 5'd1,  REG_V0 = 5'd2,  REG_V1 = 5'd3;
    localparam logic [4:0] REG_A0   = 5'd4,  REG_A1 = 5'd5,  REG_A2 = 5'd6,  REG_A3 = 5'd7;
    localparam logic [4:0] REG_T0   = 5'd8,  REG_T1 = 5'd9,  REG_T2 = 5'd10, REG_T3 = 5'd11;
    localparam logic [4:0] REG_T4   = 5'd12, REG_T5 = 5'd13, REG_T6 = 5'd14, REG_T7 = 5'd15;
    localparam logic [4:0] REG_S0   = 5'd16, REG_S1 = 5'd17, REG_S2 = 5'd18, REG_S3 = 5'd19;
    localparam logic [4:0] REG_S4   = 5'd20, REG_S5 = 5'd21, REG_S6 = 5'd22, REG_S7 = 5'd23;
    localparam logic [4:0] REG_T8   = 5'd24, REG_T9 = 5'd25, REG_K0 = 5'd26, REG_K1 = 5'd27;
    localparam logic [4:0] REG_GP   = 5'd28, REG_SP = 5'd29, REG_FP = 5'd30, REG_RA = 5'd31;

    // $at, $k0 and $k1 are not wired into the read mux
    localparam logic [31:0] RSVD_MASK = 32'h0C00_0002;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    typedef enum logic {
        LK_FREE = 1'b0,
        LK_HELD = 1'b1
    } lock_state_t;

    function automatic logic is_reserved(input logic [4:0] idx);
        return RSVD_MASK[idx];
    endfunction

    function automatic logic is_masked(input logic [4:0] idx);
        return (idx == REG_ZERO) || RSVD_MASK[idx];
    endfunction

endpackage

// File: rtl/regarb_wait_counter.sv
// Saturating counter with clear/increment and an at-limit flag; used for DMA
// starvation tracking and for bounding locked DMA bursts.
module regarb_wait_counter #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAXV = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != MAXV))
            cnt <= cnt + 1'b1;
    end

    assign at_max = (cnt == MAXV);

endmodule

// File: rtl/regfile_access_arbiter.sv
// CPU/DMA arbiter for the 32x32 MIPS register file: CPU priority with a DMA
// starvation override. Define REGARB_DMA_LOCK_EN to add the dma_lock burst feature.
module regfile_access_arbiter
    import mips_reg_pkg::*;
#(
    parameter int MAX_WAIT = 8
`ifdef REGARB_DMA_LOCK_EN
    , parameter int LOCK_MAX = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [4:0]  cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [4:0]  dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
`ifdef REGARB_DMA_LOCK_EN
    input  logic        dma_lock,
`endif
    output logic [4:0]  rf_sel,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    owner_t      win;
    owner_t      s1_owner;
    logic        win_we;
    logic [4:0]  win_addr;
    logic [31:0] win_wdata;
    logic        s1_rd_ok;
    logic        s1_rsvd;
    logic        wait_at_max;
    logic        lock_hold;

    regarb_wait_counter #(.MAX(MAX_WAIT)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .clr    (!dma_req || (win == OWN_DMA)),
        .inc    (dma_req && (win != OWN_DMA)),
        .at_max (wait_at_max)
    );

`ifdef REGARB_DMA_LOCK_EN
    lock_state_t lock_state;
    lock_state_t lock_next;
    logic        lock_at_max;
    logic        lock_inc;
    logic        lock_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lock_state <= LK_FREE;
        else
            lock_state <= lock_next;
    end

    always_comb begin
        lock_next = lock_state;
        case (lock_state)
            LK_FREE: if ((win == OWN_DMA) && dma_lock) lock_next = LK_HELD;
            LK_HELD: if (!dma_lock) lock_next = LK_FREE;
            default: lock_next = LK_FREE;
        endcase
    end

    // A held lock at its burst limit yields one cycle to normal priority, then resumes
    always_comb begin
        lock_hold = 1'b0;
        if (lock_state == LK_HELD)
            lock_hold = dma_lock && !lock_at_max;
    end

    assign lock_inc = (win == OWN_DMA) && dma_lock;
    assign lock_clr = (lock_state == LK_FREE) ? !lock_inc : (!dma_lock || lock_at_max);

    regarb_wait_counter #(.MAX(LOCK_MAX)) u_lock (
        .clk    (clk),
        .reset  (reset),
        .clr    (lock_clr),
        .inc    (lock_inc),
        .at_max (lock_at_max)
    );
`else
    assign lock_hold = 1'b0;
`endif

    always_comb begin
        win = OWN_NONE;
        if (dma_req && (lock_hold || wait_at_max || !cpu_req))
            win = OWN_DMA;
        else if (cpu_req && !lock_hold)
            win = OWN_CPU;
    end

    assign win_we    = (win == OWN_DMA) ? dma_we    : cpu_we;
    assign win_addr  = (win == OWN_DMA) ? dma_addr  : cpu_addr;
    assign win_wdata = (win == OWN_DMA) ? dma_wdata : cpu_wdata;

    // Grant stage: register-file controls are driven during the cycle after arbitration
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_gnt  <= 1'b0;
            dma_gnt  <= 1'b0;
            s1_owner <= OWN_NONE;
            s1_rd_ok <= 1'b0;
            s1_rsvd  <= 1'b0;
            rf_we    <= 1'b0;
            rf_sel   <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            cpu_gnt  <= (win == OWN_CPU);
            dma_gnt  <= (win == OWN_DMA);
            s1_owner <= win;
            s1_rd_ok <= !win_we && !is_masked(win_addr);
            s1_rsvd  <= is_reserved(win_addr);
            rf_we    <= (win != OWN_NONE) && win_we && !is_masked(win_addr);
            if (win != OWN_NONE) begin
                rf_sel   <= win_addr;
                rf_waddr <= win_addr;
                rf_wdata <= win_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
            dma_err    <= 1'b0;
        end else begin
            cpu_rvalid <= (s1_owner == OWN_CPU);
            dma_rvalid <= (s1_owner == OWN_DMA);
            cpu_rdata  <= ((s1_owner == OWN_CPU) && s1_rd_ok) ? rf_rdata : '0;
            dma_rdata  <= ((s1_owner == OWN_DMA) && s1_rd_ok) ? rf_rdata : '0;
            dma_err    <= (s1_owner == OWN_DMA) && s1_rsvd;
        end
    end

endmodule
